// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: architectural widths, the x0 address and the
// scoreboard set/clear request.
package rv32i_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  en;
    logic [REG_ADDR_W-1:0] rd;
  } sb_req_t;
endpackage

// File: rtl/regfile_if.sv
// Writeback write port, decode read ports and the load scoreboard, bundled between
// the pipeline (master) and the register file (slave).
interface regfile_if
  import rv32i_pkg::*;
#(parameter int XLEN = 32);
  logic                  regfile_w_en;
  logic [REG_ADDR_W-1:0] regfile_w_reg;
  logic [XLEN-1:0]       regfile_w_data;
  logic [REG_ADDR_W-1:0] rs1, rs2;
  logic                  rs1_used, rs2_used;
  logic [XLEN-1:0]       rs1_val, rs2_val;
  logic                  sb_set_en;
  logic [REG_ADDR_W-1:0] sb_set_reg;
  logic                  rs1_busy, rs2_busy;
  logic                  stall;

  modport master (
    output regfile_w_en, regfile_w_reg, regfile_w_data, rs1, rs2, rs1_used, rs2_used,
           sb_set_en, sb_set_reg,
    input  rs1_val, rs2_val, rs1_busy, rs2_busy, stall
  );

  modport slave (
    input  regfile_w_en, regfile_w_reg, regfile_w_data, rs1, rs2, rs1_used, rs2_used,
           sb_set_en, sb_set_reg,
    output rs1_val, rs2_val, rs1_busy, rs2_busy, stall
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Load-pending bit per register plus the decode interlock. A same-cycle set beats
// a same-cycle clear because the new load is younger than the completing write.
module regfile_scoreboard
  import rv32i_pkg::*;
#(parameter int NREGS = 32) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  sb_req_t               sb_set,
  input  sb_req_t               sb_clr,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  stall
);
  // bit 0 exists only so rs==0 indexes a permanently clear bit
  logic [NREGS-1:0] pending, pending_nxt;

  always_comb begin
    pending_nxt = pending;
    if (sb_clr.en && sb_clr.rd != REG_ZERO) pending_nxt[sb_clr.rd] = 1'b0;
    if (sb_set.en && sb_set.rd != REG_ZERO) pending_nxt[sb_set.rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;

  // the completing write is already bypassed, so it no longer blocks
  assign rs1_busy = pending[rs1] & ~(sb_clr.en & (sb_clr.rd == rs1));
  assign rs2_busy = pending[rs2] & ~(sb_clr.en & (sb_clr.rd == rs2));
  assign stall    = (rs1_used & rs1_busy) | (rs2_used & rs2_busy);
endmodule

// File: rtl/regfile.sv
// RV32I architectural register file: x0 hardwired to zero, combinational reads with
// write-first bypass, and a load scoreboard for load-use interlock.
module regfile
  import rv32i_pkg::*;
#(parameter int XLEN = 32, parameter int NREGS = 32) (
  input logic      clk,
  input logic      rst_n,
  regfile_if.slave bus
);
  localparam int NRD = 2;

  sb_req_t sb_set, sb_clr;
  assign sb_set = '{en: bus.sb_set_en,    rd: bus.sb_set_reg};
  assign sb_clr = '{en: bus.regfile_w_en, rd: bus.regfile_w_reg};

  logic [XLEN-1:0] regs [1:NREGS-1];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
    end else if (sb_clr.en && sb_clr.rd != REG_ZERO) begin
      regs[sb_clr.rd] <= bus.regfile_w_data;
    end

  logic [NRD-1:0][REG_ADDR_W-1:0] rd_addr;
  logic [NRD-1:0][XLEN-1:0]       rd_val;
  assign rd_addr = {bus.rs2, bus.rs1};

  // bypass is gated by reset so nothing presented during reset leaks to decode
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    assign rd_val[p] = (!rst_n || rd_addr[p] == REG_ZERO)             ? '0 :
                       (sb_clr.en && sb_clr.rd == rd_addr[p])         ? bus.regfile_w_data :
                                                                        regs[rd_addr[p]];
  end

  assign bus.rs1_val = rd_val[0];
  assign bus.rs2_val = rd_val[1];

  regfile_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .sb_set   (sb_set),
    .sb_clr   (sb_clr),
    .rs1      (bus.rs1),
    .rs2      (bus.rs2),
    .rs1_used (bus.rs1_used),
    .rs2_used (bus.rs2_used),
    .rs1_busy (bus.rs1_busy),
    .rs2_busy (bus.rs2_busy),
    .stall    (bus.stall)
  );
endmodule

// File: tb/tb_regfile.sv
// Directed and random checks of the register file against an architectural model
// (register contents + set of registers with a load outstanding).
module tb_regfile;
  logic clk = 1'b0;
  logic rst_n;
  regfile_if #(.XLEN(32)) bus ();

  regfile #(.XLEN(32), .NREGS(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  logic [31:0] mregs [32];
  bit          mpend [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin mregs[i] = '0; mpend[i] = 1'b0; end
  endtask

  function automatic logic [31:0] exp_val(input logic [4:0] a);
    if (!rst_n || a == 0) return '0;
    if (bus.regfile_w_en && bus.regfile_w_reg == a) return bus.regfile_w_data;
    return mregs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!rst_n || a == 0) return 1'b0;
    return mpend[a] && !(bus.regfile_w_en && bus.regfile_w_reg == a);
  endfunction

  task automatic check_all(input string tag);
    logic b1, b2;
    b1 = exp_busy(bus.rs1);
    b2 = exp_busy(bus.rs2);
    chk({tag, ".rs1_val"},  bus.rs1_val,  exp_val(bus.rs1));
    chk({tag, ".rs2_val"},  bus.rs2_val,  exp_val(bus.rs2));
    chk({tag, ".rs1_busy"}, {31'd0, bus.rs1_busy}, {31'd0, b1});
    chk({tag, ".rs2_busy"}, {31'd0, bus.rs2_busy}, {31'd0, b2});
    chk({tag, ".stall"},    {31'd0, bus.stall},
        {31'd0, (bus.rs1_used & b1) | (bus.rs2_used & b2)});
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic u1,
                       input logic u2, input logic se, input logic [4:0] sr);
    bus.regfile_w_en = we; bus.regfile_w_reg = wr; bus.regfile_w_data = wd;
    bus.rs1 = a1; bus.rs2 = a2; bus.rs1_used = u1; bus.rs2_used = u2;
    bus.sb_set_en = se; bus.sb_set_reg = sr;
  endtask

  // one rising edge; the model commits the inputs that were stable across it
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      if (bus.regfile_w_en && bus.regfile_w_reg != 0) begin
        mregs[bus.regfile_w_reg] = bus.regfile_w_data;
        mpend[bus.regfile_w_reg] = 1'b0;
      end
      if (bus.sb_set_en && bus.sb_set_reg != 0) mpend[bus.sb_set_reg] = 1'b1;
    end
    #1;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    // writes, sets and bypass candidates during reset must all be ignored
    drive(1'b1, 5'd7, 32'hCAFE_F00D, 5'd7, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4);
    #2;
    check_all("in_reset");
    chk("in_reset.bypass_off", bus.rs1_val, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0);
    #1;
    check_all("post_reset_x4");
    for (int r = 1; r < 32; r++) begin
      bus.rs1 = 5'(r); bus.rs2 = 5'(32 - r);
      #1;
      chk($sformatf("reset_x%0d", r), bus.rs1_val, 32'h0);
    end

    // x0 writes are dropped, x0 scoreboard set is a no-op
    drive(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0);
    tick();
    drive(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0);
    #1;
    chk("x0_read", bus.rs1_val, 32'h0);
    chk("x0_busy", {31'd0, bus.rs1_busy}, 32'h0);
    check_all("x0");

    // bypass in the write cycle, array value the cycle after
    drive(1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0);
    #1;
    chk("bypass_rs1", bus.rs1_val, 32'hA5A5_A5A5);
    chk("bypass_rs2", bus.rs2_val, 32'hA5A5_A5A5);
    tick();
    drive(1'b1, 5'd0, 32'h0, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0);
    #1;
    chk("commit_rs1", bus.rs1_val, 32'hA5A5_A5A5);
    chk("commit_rs2", bus.rs2_val, 32'hA5A5_A5A5);

    // load-use interlock on x3
    drive(1'b1, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3);
    tick();
    drive(1'b1, 5'd0, 32'h0, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0);
    #1;
    chk("lu_n1_stall", {31'd0, bus.stall}, 32'h1);
    check_all("lu_n1");
    tick();
    chk("lu_n2_stall", {31'd0, bus.stall}, 32'h1);
    drive(1'b1, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    chk("unused_busy", {31'd0, bus.rs1_busy}, 32'h1);
    chk("unused_stall", {31'd0, bus.stall}, 32'h0);
    tick();
    drive(1'b1, 5'd3, 32'h55, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0);
    #1;
    chk("lu_wb_stall", {31'd0, bus.stall}, 32'h0);
    chk("lu_wb_val", bus.rs2_val, 32'h55);
    tick();
    drive(1'b1, 5'd0, 32'h0, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0);
    #1;
    chk("lu_after_busy", {31'd0, bus.rs1_busy}, 32'h0);
    check_all("lu_after");

    // simultaneous set and clear of x9: set wins, data still lands
    drive(1'b1, 5'd9, 32'h9999_0009, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9);
    tick();
    drive(1'b1, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0);
    #1;
    chk("setclr_busy", {31'd0, bus.rs1_busy}, 32'h1);
    chk("setclr_val", bus.rs1_val, 32'h9999_0009);
    check_all("setclr");

    // random traffic on a narrow register window to force collisions
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
      #1;
      check_all($sformatf("rand%0d", i));
      tick();
    end

    // asynchronous reset mid-run clears data and pending without a clock edge
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6);
    tick();
    drive(1'b1, 5'd0, 32'h0, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 5'd0);
    #1;
    chk("pre_rst_x5", bus.rs1_val, 32'hDEAD_BEEF);
    chk("pre_rst_stall", {31'd0, bus.stall}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_x5", bus.rs1_val, 32'h0);
    chk("async_rst_stall", {31'd0, bus.stall}, 32'h0);
    model_reset();
    check_all("async_rst");
    rst_n = 1'b1;
    #1;
    check_all("rst_release");
    tick();
    check_all("rst_after_edge");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
